// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the CPU datapath: ALU opcodes, branch kinds, load/store kinds.
// Pure definitions plus the forwarding-match helper; no state, no handshake.
package cpu_defs_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_LUI  = 4'hB
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLEZ = 3'd2,
        BR_BGTZ = 3'd3,
        BR_BLTZ = 3'd4,
        BR_BGEZ = 3'd5
    } br_type_e;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_B    = 3'd1;
    localparam logic [2:0] LD_H    = 3'd2;
    localparam logic [2:0] LD_W    = 3'd3;
    localparam logic [2:0] LD_BU   = 3'd4;
    localparam logic [2:0] LD_HU   = 3'd5;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_B    = 2'd1;
    localparam logic [1:0] ST_H    = 2'd2;
    localparam logic [1:0] ST_W    = 2'd3;

    // Register 0 is hardwired to zero, so a write to it must never be forwarded.
    function automatic logic fwd_hit(
        input logic       wen,
        input logic [4:0] wreg,
        input logic [4:0] src
    );
        return wen && (wreg != 5'd0) && (wreg == src);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; zero latency, no handshake.
// Shifts operate on i_b by i_shamt; LUI places i_b[15:0] in the upper half.
module alu
    import cpu_defs_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_SLT:  o_result = {31'd0, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {31'd0, (i_a < i_b)};
            ALU_SLL:  o_result = i_b << i_shamt;
            ALU_SRL:  o_result = i_b >> i_shamt;
            ALU_SRA:  o_result = $signed(i_b) >>> i_shamt;
            ALU_LUI:  o_result = {i_b[15:0], 16'h0000};
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution, EX/MEM pipeline register.
// EX/MEM outputs register 1 cycle after ID/EX; redirect/target are combinational; no stall input.
module ex_stage
    import cpu_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_ex_rs,
    input  logic [4:0]  id_ex_rt,
    input  logic [4:0]  id_ex_rd,
    input  logic [4:0]  id_ex_shamt,
    input  logic [31:0] id_ex_imm_sign_extended,
    input  logic [31:0] id_ex_pc_next,
    input  logic [3:0]  id_ex_ctrl_alu_control,
    input  logic        id_ex_ctrl_alu_src,
    input  logic        id_ex_ctrl_alu_shift_shamt,
    input  logic        id_ex_ctrl_branch,
    input  logic        id_ex_ctrl_jump,
    input  logic        id_ex_ctrl_jump_reg,
    input  logic        id_ex_ctrl_mem_to_reg,
    input  logic        id_ex_ctrl_mem_write,
    input  logic        id_ex_ctrl_reg_dst,
    input  logic        id_ex_ctrl_reg_write,
    input  logic [2:0]  id_ex_ctrl_load_type,
    input  logic [1:0]  id_ex_ctrl_store_type,
    input  logic [2:0]  id_ex_ctrl_branch_type,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mem_wb_reg_write,
    input  logic [4:0]  mem_wb_write_reg,
    input  logic [31:0] mem_wb_data,
    output logic [31:0] ex_mem_alu_result,
    output logic [31:0] ex_mem_store_data,
    output logic [4:0]  ex_mem_write_reg,
    output logic        ex_mem_ctrl_reg_write,
    output logic        ex_mem_ctrl_mem_to_reg,
    output logic        ex_mem_ctrl_mem_write,
    output logic [2:0]  ex_mem_ctrl_load_type,
    output logic [1:0]  ex_mem_ctrl_store_type,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        flush_id
);

    logic [31:0] r_alu_result;
    logic [31:0] r_store_data;
    logic [4:0]  r_write_reg;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic        r_mem_write;
    logic [2:0]  r_load_type;
    logic [1:0]  r_store_type;

    logic        w_ex_fwd_en;
    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_alu_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_alu_result;
    logic [4:0]  w_write_reg;
    logic        w_br_cond;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic        w_redirect;

    // A load in EX/MEM has no data yet, so only ALU results are forwarded from there.
    assign w_ex_fwd_en = r_reg_write && !r_mem_to_reg;

    always_comb begin
        w_fwd_a = rs_data;
        if (fwd_hit(w_ex_fwd_en, r_write_reg, id_ex_rs)) begin
            w_fwd_a = r_alu_result;
        end else if (fwd_hit(mem_wb_reg_write, mem_wb_write_reg, id_ex_rs)) begin
            w_fwd_a = mem_wb_data;
        end
    end

    always_comb begin
        w_fwd_b = rt_data;
        if (fwd_hit(w_ex_fwd_en, r_write_reg, id_ex_rt)) begin
            w_fwd_b = r_alu_result;
        end else if (fwd_hit(mem_wb_reg_write, mem_wb_write_reg, id_ex_rt)) begin
            w_fwd_b = mem_wb_data;
        end
    end

    assign w_alu_b     = id_ex_ctrl_alu_src ? id_ex_imm_sign_extended : w_fwd_b;
    assign w_shamt     = id_ex_ctrl_alu_shift_shamt ? id_ex_shamt : w_fwd_a[4:0];
    assign w_write_reg = id_ex_ctrl_reg_dst ? id_ex_rd : id_ex_rt;

    alu u_alu (
        .i_op     (id_ex_ctrl_alu_control),
        .i_a      (w_fwd_a),
        .i_b      (w_alu_b),
        .i_shamt  (w_shamt),
        .o_result (w_alu_result)
    );

    always_comb begin
        w_br_cond = 1'b0;
        case (id_ex_ctrl_branch_type)
            BR_BEQ:  w_br_cond = (w_fwd_a == w_fwd_b);
            BR_BNE:  w_br_cond = (w_fwd_a != w_fwd_b);
            BR_BLEZ: w_br_cond = ($signed(w_fwd_a) <= 32'sd0);
            BR_BGTZ: w_br_cond = ($signed(w_fwd_a) >  32'sd0);
            BR_BLTZ: w_br_cond = ($signed(w_fwd_a) <  32'sd0);
            BR_BGEZ: w_br_cond = ($signed(w_fwd_a) >= 32'sd0);
            default: w_br_cond = 1'b0;
        endcase
    end

    // The jump index is rebuilt from the rs/rt/imm fields the decoder split it into.
    assign w_br_target = id_ex_pc_next + {id_ex_imm_sign_extended[29:0], 2'b00};
    assign w_j_target  = {id_ex_pc_next[31:28], id_ex_rs, id_ex_rt,
                          id_ex_imm_sign_extended[15:0], 2'b00};

    assign w_redirect = id_ex_ctrl_jump_reg || id_ex_ctrl_jump
                        || (id_ex_ctrl_branch && w_br_cond);

    always_comb begin
        if (id_ex_ctrl_jump_reg) begin
            pc_target = w_fwd_a;
        end else if (id_ex_ctrl_jump) begin
            pc_target = w_j_target;
        end else begin
            pc_target = w_br_target;
        end
    end

    assign pc_redirect = w_redirect;
    assign flush_id    = w_redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_result <= '0;
            r_store_data <= '0;
            r_write_reg  <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_load_type  <= '0;
            r_store_type <= '0;
        end else begin
            r_alu_result <= w_alu_result;
            r_store_data <= w_fwd_b;
            r_write_reg  <= w_write_reg;
            r_reg_write  <= id_ex_ctrl_reg_write;
            r_mem_to_reg <= id_ex_ctrl_mem_to_reg;
            r_mem_write  <= id_ex_ctrl_mem_write;
            r_load_type  <= id_ex_ctrl_load_type;
            r_store_type <= id_ex_ctrl_store_type;
        end
    end

    assign ex_mem_alu_result      = r_alu_result;
    assign ex_mem_store_data      = r_store_data;
    assign ex_mem_write_reg       = r_write_reg;
    assign ex_mem_ctrl_reg_write  = r_reg_write;
    assign ex_mem_ctrl_mem_to_reg = r_mem_to_reg;
    assign ex_mem_ctrl_mem_write  = r_mem_write;
    assign ex_mem_ctrl_load_type  = r_load_type;
    assign ex_mem_ctrl_store_type = r_store_type;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed pipeline scenarios, then random instruction stream.
// Expected responses come from an instruction-level model and are checked by a separate monitor.
module tb_ex_stage;
    import cpu_defs_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt;
    logic [31:0] id_ex_imm_sign_extended, id_ex_pc_next;
    logic [3:0]  id_ex_ctrl_alu_control;
    logic        id_ex_ctrl_alu_src, id_ex_ctrl_alu_shift_shamt, id_ex_ctrl_branch;
    logic        id_ex_ctrl_jump, id_ex_ctrl_jump_reg, id_ex_ctrl_mem_to_reg;
    logic        id_ex_ctrl_mem_write, id_ex_ctrl_reg_dst, id_ex_ctrl_reg_write;
    logic [2:0]  id_ex_ctrl_load_type, id_ex_ctrl_branch_type;
    logic [1:0]  id_ex_ctrl_store_type;
    logic [31:0] rs_data, rt_data;
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_write_reg;
    logic [31:0] mem_wb_data;
    logic [31:0] ex_mem_alu_result, ex_mem_store_data;
    logic [4:0]  ex_mem_write_reg;
    logic        ex_mem_ctrl_reg_write, ex_mem_ctrl_mem_to_reg, ex_mem_ctrl_mem_write;
    logic [2:0]  ex_mem_ctrl_load_type;
    logic [1:0]  ex_mem_ctrl_store_type;
    logic        pc_redirect, flush_id;
    logic [31:0] pc_target;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_shamt(id_ex_shamt),
        .id_ex_imm_sign_extended(id_ex_imm_sign_extended), .id_ex_pc_next(id_ex_pc_next),
        .id_ex_ctrl_alu_control(id_ex_ctrl_alu_control), .id_ex_ctrl_alu_src(id_ex_ctrl_alu_src),
        .id_ex_ctrl_alu_shift_shamt(id_ex_ctrl_alu_shift_shamt), .id_ex_ctrl_branch(id_ex_ctrl_branch),
        .id_ex_ctrl_jump(id_ex_ctrl_jump), .id_ex_ctrl_jump_reg(id_ex_ctrl_jump_reg),
        .id_ex_ctrl_mem_to_reg(id_ex_ctrl_mem_to_reg), .id_ex_ctrl_mem_write(id_ex_ctrl_mem_write),
        .id_ex_ctrl_reg_dst(id_ex_ctrl_reg_dst), .id_ex_ctrl_reg_write(id_ex_ctrl_reg_write),
        .id_ex_ctrl_load_type(id_ex_ctrl_load_type), .id_ex_ctrl_store_type(id_ex_ctrl_store_type),
        .id_ex_ctrl_branch_type(id_ex_ctrl_branch_type),
        .rs_data(rs_data), .rt_data(rt_data),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_write_reg(mem_wb_write_reg),
        .mem_wb_data(mem_wb_data),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
        .ex_mem_write_reg(ex_mem_write_reg), .ex_mem_ctrl_reg_write(ex_mem_ctrl_reg_write),
        .ex_mem_ctrl_mem_to_reg(ex_mem_ctrl_mem_to_reg), .ex_mem_ctrl_mem_write(ex_mem_ctrl_mem_write),
        .ex_mem_ctrl_load_type(ex_mem_ctrl_load_type), .ex_mem_ctrl_store_type(ex_mem_ctrl_store_type),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .flush_id(flush_id)
    );

    typedef struct {
        logic [4:0]  rs, rt, rd, shamt;
        logic [31:0] imm, pc_next, rs_data, rt_data;
        logic [3:0]  alu;
        logic        alu_src, sh_shamt, branch, jump, jump_reg;
        logic        mem_to_reg, mem_write, reg_dst, reg_write;
        logic [2:0]  load_type, br_type;
        logic [1:0]  store_type;
        logic        wb_we;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic        rst;
    } stim_t;

    typedef struct {
        int          cyc;
        logic        redirect;
        logic [31:0] target;
    } exp_comb_t;

    typedef struct {
        int          cyc;
        logic [31:0] result, store;
        logic [4:0]  wreg;
        logic        rw, m2r, mw;
        logic [2:0]  lt;
        logic [1:0]  st;
    } exp_reg_t;

    exp_comb_t q_comb[$];
    exp_reg_t  q_reg[$];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model of what the EX/MEM latch holds architecturally after the last issued instruction.
    logic        m_rw = 1'b0, m_m2r = 1'b0;
    logic [4:0]  m_wr = '0;
    logic [31:0] m_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] rf,
                                            input stim_t s);
        if (src != 0 && m_rw && !m_m2r && m_wr == src) return m_res;
        if (src != 0 && s.wb_we && s.wb_reg == src)      return s.wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int sa);
        logic [31:0] ones, r;
        ones = 32'hFFFF_FFFF;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~(a | b);
            4'h6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h7: return (a < b) ? 32'd1 : 32'd0;
            4'h8: return b << sa;
            4'h9: return b >> sa;
            4'hA: begin
                r = b >> sa;
                if (b[31]) r = r | ~(ones >> sa);
                return r;
            end
            4'hB: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic taken_ref(input logic [2:0] t, input logic [31:0] a,
                                       input logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (t)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return sa <= 0;
            3'd3: return sa > 0;
            3'd4: return sa < 0;
            3'd5: return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic apply(input stim_t s);
        logic [31:0] a, b, res, tgt;
        logic        redir;
        exp_comb_t   ec;
        exp_reg_t    er;
        @(posedge clk);
        #1;
        rst = s.rst;
        id_ex_rs = s.rs; id_ex_rt = s.rt; id_ex_rd = s.rd; id_ex_shamt = s.shamt;
        id_ex_imm_sign_extended = s.imm; id_ex_pc_next = s.pc_next;
        id_ex_ctrl_alu_control = s.alu; id_ex_ctrl_alu_src = s.alu_src;
        id_ex_ctrl_alu_shift_shamt = s.sh_shamt; id_ex_ctrl_branch = s.branch;
        id_ex_ctrl_jump = s.jump; id_ex_ctrl_jump_reg = s.jump_reg;
        id_ex_ctrl_mem_to_reg = s.mem_to_reg; id_ex_ctrl_mem_write = s.mem_write;
        id_ex_ctrl_reg_dst = s.reg_dst; id_ex_ctrl_reg_write = s.reg_write;
        id_ex_ctrl_load_type = s.load_type; id_ex_ctrl_store_type = s.store_type;
        id_ex_ctrl_branch_type = s.br_type;
        rs_data = s.rs_data; rt_data = s.rt_data;
        mem_wb_reg_write = s.wb_we; mem_wb_write_reg = s.wb_reg; mem_wb_data = s.wb_data;

        a   = operand(s.rs, s.rs_data, s);
        b   = operand(s.rt, s.rt_data, s);
        res = alu_ref(s.alu, a, s.alu_src ? s.imm : b, s.sh_shamt ? int'(s.shamt) : int'(a[4:0]));
        redir = s.jump_reg || s.jump || (s.branch && taken_ref(s.br_type, a, b));
        if (s.jump_reg)  tgt = a;
        else if (s.jump) tgt = (s.pc_next & 32'hF000_0000)
                               + ((s.rs * 32'd2097152 + s.rt * 32'd65536 + (s.imm & 32'hFFFF)) * 4);
        else             tgt = s.pc_next + s.imm * 4;
        ec = '{cyc: cyc, redirect: redir, target: tgt};
        q_comb.push_back(ec);

        if (s.rst) begin
            er = '{cyc: cyc, result: 0, store: 0, wreg: 0, rw: 0, m2r: 0, mw: 0, lt: 0, st: 0};
        end else begin
            er = '{cyc: cyc, result: res, store: b, wreg: s.reg_dst ? s.rd : s.rt,
                   rw: s.reg_write, m2r: s.mem_to_reg, mw: s.mem_write,
                   lt: s.load_type, st: s.store_type};
        end
        q_reg.push_back(er);
        m_rw = er.rw; m_m2r = er.m2r; m_wr = er.wreg; m_res = er.result;
    endtask

    always @(negedge clk) begin
        exp_comb_t ec;
        exp_reg_t  er;
        if (q_comb.size() > 0 && q_comb[0].cyc == cyc) begin
            ec = q_comb.pop_front();
            chk("pc_redirect", pc_redirect, ec.redirect);
            chk("flush_id", flush_id, ec.redirect);
            if (ec.redirect) chk("pc_target", pc_target, ec.target);
        end
        if (q_reg.size() > 0 && q_reg[0].cyc < cyc) begin
            er = q_reg.pop_front();
            chk("alu_result", ex_mem_alu_result, er.result);
            chk("store_data", ex_mem_store_data, er.store);
            chk("write_reg", ex_mem_write_reg, er.wreg);
            chk("reg_write", ex_mem_ctrl_reg_write, er.rw);
            chk("mem_to_reg", ex_mem_ctrl_mem_to_reg, er.m2r);
            chk("mem_write", ex_mem_ctrl_mem_write, er.mw);
            chk("load_type", ex_mem_ctrl_load_type, er.lt);
            chk("store_type", ex_mem_ctrl_store_type, er.st);
        end
    end

    function automatic stim_t bubble();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        logic [15:0] h;
        s = bubble();
        h = 16'($urandom);
        s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
        s.rd = 5'($urandom_range(0, 3)); s.shamt = 5'($urandom);
        s.imm = ($urandom_range(0, 1) == 1) ? {{16{h[15]}}, h} : $urandom;
        s.pc_next = $urandom; s.rs_data = $urandom; s.rt_data = $urandom;
        s.alu = 4'($urandom);
        s.alu_src = 1'($urandom); s.sh_shamt = 1'($urandom);
        if (s.alu == ALU_LUI) s.alu_src = 1'b1;
        s.branch = ($urandom_range(0, 3) == 0);
        s.jump = ($urandom_range(0, 7) == 0);
        s.jump_reg = ($urandom_range(0, 7) == 0);
        s.br_type = 3'($urandom);
        if ($urandom_range(0, 3) == 0) s.rt_data = s.rs_data;
        s.mem_to_reg = 1'($urandom); s.mem_write = 1'($urandom);
        s.reg_dst = 1'($urandom); s.reg_write = 1'($urandom);
        s.load_type = 3'($urandom); s.store_type = 2'($urandom);
        s.wb_we = 1'($urandom); s.wb_reg = 5'($urandom_range(0, 3)); s.wb_data = $urandom;
        s.rst = ($urandom_range(0, 19) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        s = bubble(); s.rst = 1'b1;
        apply(s);
        apply(s);
        @(negedge clk);
        chk("reset_alu_result", ex_mem_alu_result, 32'd0);

        // ADD r1 = 5 + 7, then SUB r2 = r1 - r1 through EX/MEM forwarding
        s = bubble(); s.alu = ALU_ADD; s.rs = 5'd8; s.rt = 5'd9; s.rs_data = 5; s.rt_data = 7;
        s.rd = 5'd1; s.reg_dst = 1; s.reg_write = 1;
        apply(s);
        s = bubble(); s.alu = ALU_SUB; s.rs = 5'd1; s.rt = 5'd1; s.rs_data = 99; s.rt_data = 42;
        s.rd = 5'd2; s.reg_dst = 1; s.reg_write = 1;
        apply(s);
        @(negedge clk);
        chk("add_result", ex_mem_alu_result, 32'd12);

        // OR r4, r3, r0 while MEM/WB writes r3
        s = bubble(); s.alu = ALU_OR; s.rs = 5'd3; s.rt = 5'd0; s.rd = 5'd4;
        s.reg_dst = 1; s.reg_write = 1; s.wb_we = 1; s.wb_reg = 5'd3; s.wb_data = 32'hDEAD_BEEF;
        apply(s);
        @(negedge clk);
        chk("sub_fwd_result", ex_mem_alu_result, 32'd0);

        s = bubble(); s.branch = 1; s.br_type = BR_BEQ; s.rs = 5'd10; s.rt = 5'd11;
        s.rs_data = 9; s.rt_data = 9; s.pc_next = 32'h100; s.imm = 32'hFFFF_FFFF;
        apply(s);
        @(negedge clk);
        chk("or_wb_fwd_result", ex_mem_alu_result, 32'hDEAD_BEEF);
        chk("beq_redirect", pc_redirect, 32'd1);
        chk("beq_target", pc_target, 32'h0000_00FC);
        s.br_type = BR_BNE;
        apply(s);
        @(negedge clk);
        chk("bne_redirect", pc_redirect, 32'd0);

        s = bubble(); s.jump_reg = 1; s.rs = 5'd7; s.wb_we = 1; s.wb_reg = 5'd7; s.wb_data = 32'h400;
        apply(s);
        @(negedge clk);
        chk("jr_target", pc_target, 32'h400);
        s = bubble(); s.jump = 1; s.pc_next = 32'h8000_0010; s.rs = 5'd1; s.rt = 5'd2;
        s.imm = 32'h0000_3456;
        apply(s);
        @(negedge clk);
        chk("j_target", pc_target, 32'h8088_D158);

        // Write to r0 must not forward; SRA 0x80000000 by 4
        s = bubble(); s.alu = ALU_ADD; s.rs = 5'd8; s.rt = 5'd9; s.rs_data = 1; s.rt_data = 2;
        s.rd = 5'd0; s.reg_dst = 1; s.reg_write = 1;
        apply(s);
        s = bubble(); s.alu = ALU_SRA; s.rs = 5'd0; s.rt = 5'd0; s.rt_data = 32'h8000_0000;
        s.sh_shamt = 1; s.shamt = 5'd4; s.rd = 5'd5; s.reg_dst = 1; s.reg_write = 1;
        s.wb_we = 1; s.wb_reg = 5'd0; s.wb_data = 32'h1234_5678;
        apply(s);
        s = bubble(); s.mem_write = 1; s.store_type = ST_W; s.alu = ALU_ADD; s.alu_src = 1;
        s.rs = 5'd8; s.rt = 5'd9; s.rs_data = 32'h1000; s.rt_data = 32'hCAFE; s.imm = 8;
        s.rst = 1'b1;
        apply(s);
        @(negedge clk);
        chk("sra_result", ex_mem_alu_result, 32'hF800_0000);
        chk("sra_store_no_fwd", ex_mem_store_data, 32'h8000_0000);
        apply(bubble());
        @(negedge clk);
        chk("rst_store_alu", ex_mem_alu_result, 32'd0);
        chk("rst_store_data", ex_mem_store_data, 32'd0);
        chk("rst_store_mem_write", ex_mem_ctrl_mem_write, 32'd0);
        chk("rst_store_type", ex_mem_ctrl_store_type, 32'd0);

        for (int i = 0; i < 400; i++) apply(rand_stim());
        apply(bubble());
        apply(bubble());

        for (int i = 0; i < 10 && q_reg.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (q_reg.size() != 0 || q_comb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d register and %0d comb expectations left, expected 0",
                     q_reg.size(), q_comb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
